// File: rtl/uart_cdc_pkg.sv
// Shared constants and helpers for the byte-stream to UART bridge.
package uart_cdc_pkg;

  // Default bit period: 48 MHz system clock, 115200 baud.
  localparam int UART_CLKS_PER_BIT = 417;

  // Offset from the first low sample of a start bit to the mid-bit sample point.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: input synchronizer, 8N1 deframer, single-entry holding
// register with valid/ready output, frame-error and overrun pulses.
module uart_rx
  import uart_cdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int            CW           = $clog2(CLKS_PER_BIT);
  localparam int            LP_HALF      = half_bit(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_ONE       = CW'(1);
  localparam logic [CW-1:0] LP_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_LAST = CW'(LP_HALF - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_byte_done;
  logic          r_frame_err;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_overrun;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // Deframer: mid-bit sampling, false-start rejection, break/framing recovery.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_cnt   <= '0;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == LP_HALF_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // A line that is high again at mid-start was only a glitch.
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        RX_DATA: begin
          if (r_cnt == LP_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_idx == 3'd7) r_state <= RX_STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        RX_STOP: begin
          if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
            if (w_rx) begin
              // Leave half a bit early so the next start edge is caught promptly.
              r_byte_done <= 1'b1;
              r_state     <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= RX_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        RX_WAIT_IDLE: begin
          if (w_rx) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  // Holding register: keeps the oldest unconsumed byte, flags drops as overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_byte_done) begin
        if (r_out_valid && !out_ready_i) begin
          r_overrun <= 1'b1;
        end else begin
          r_out_data  <= r_shift;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule

// File: rtl/uart_cdc.sv
// Byte-stream to 8N1 UART bridge: valid/ready transmit stream serialized on
// uart_tx_o, received bytes presented on a valid/ready output stream.
module uart_cdc
  import uart_cdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT  // minimum 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);
  localparam logic [CW-1:0] LP_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_READY = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_byte;
  logic          r_tx;
  logic          r_in_ready;
  logic          w_tx_fire;

  assign w_tx_fire = in_valid_i & r_in_ready;

  // Transmitter: latch byte on handshake, shift out start/data/stop, and accept
  // the next byte on the last stop cycle so frames run back to back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_byte  <= '0;
      r_tx       <= 1'b1;
      r_in_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_tx_fire) begin
            r_tx_byte  <= in_data_i;
            r_in_ready <= 1'b0;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx       <= r_tx_byte[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + LP_ONE;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_idx <= r_tx_idx + 3'd1;
              r_tx     <= r_tx_byte[r_tx_idx + 3'd1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + LP_ONE;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == LP_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_fire) begin
              r_tx_byte  <= in_data_i;
              r_in_ready <= 1'b0;
              r_tx       <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + LP_ONE;
            // Ready goes high for exactly the final stop cycle.
            if (r_tx_cnt == LP_READY) r_in_ready <= 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx_o  = r_tx;
  assign in_ready_o = r_in_ready;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (uart_rx_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .frame_err_o (rx_frame_err_o),
    .overrun_o   (rx_overrun_o)
  );

endmodule

// File: tb/tb_uart_cdc.sv
// Directed self-checking bench for uart_cdc with an 8-clock bit period.
module tb_uart_cdc;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  // Passive monitor state, sampled on the falling edge.
  int   cyc       = 0;
  int   rise_cnt  = 0;
  int   rise_cyc  = -1;
  int   err_cnt   = 0;
  int   err_cyc   = -1;
  int   ovr_cnt   = 0;
  logic prev_valid = 1'b0;

  uart_cdc #(.CLKS_PER_BIT(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .uart_tx_o      (uart_tx),
    .uart_rx_i      (uart_rx),
    .rx_frame_err_o (frame_err),
    .rx_overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    prev_valid = out_valid;
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  // Hand a byte to the transmitter and check all 80 cycles of its frame.
  task automatic send_tx_and_check(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 10 * N; j++) begin
      checks++;
      if (uart_tx !== frame_bit(b, j / N)) begin
        failures++;
        $display("FAIL tx_bit byte=%h cyc=%0d got=%b exp=%b", b, j, uart_tx, frame_bit(b, j / N));
      end
      checks++;
      if (in_ready !== (j == 10 * N - 1)) begin
        failures++;
        $display("FAIL tx_ready byte=%h cyc=%0d got=%b exp=%b", b, j, in_ready, (j == 10 * N - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (uart_tx !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL tx_idle_after got tx=%b rdy=%b exp tx=1 rdy=1", uart_tx, in_ready);
    end
  endtask

  // Drive one 8N1 frame on the serial input, one bit per N cycles.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      uart_rx = (i == 9) ? stop : frame_bit(b, i);
      repeat (N) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL consume_clear got valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got tx=%b rdy=%b vld=%b data=%h ferr=%b ovr=%b exp 1 1 0 00 0 0",
               uart_tx, in_ready, out_valid, out_data, frame_err, overrun);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx;
    send_tx_and_check(8'hA5);
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    @(negedge clk);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hFF;
    for (int j = 0; j < 20 * N; j++) begin
      if (j == 10 * N) in_valid = 1'b0;
      b = (j < 10 * N) ? 8'h00 : 8'hFF;
      checks++;
      if (uart_tx !== frame_bit(b, (j % (10 * N)) / N)) begin
        failures++;
        $display("FAIL b2b_bit cyc=%0d got=%b exp=%b", j, uart_tx, frame_bit(b, (j % (10 * N)) / N));
      end
      checks++;
      if (in_ready !== ((j % (10 * N)) == 10 * N - 1)) begin
        failures++;
        $display("FAIL b2b_ready cyc=%0d got=%b", j, in_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (uart_tx !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle got tx=%b rdy=%b exp 1 1", uart_tx, in_ready);
    end
  endtask

  task automatic test_rx;
    int s;
    int r0;
    out_ready = 1'b0;
    r0 = rise_cnt;
    s  = cyc;
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rise_cnt !== r0 + 1 || rise_cyc !== s + 80) begin
      failures++;
      $display("FAIL rx_latency got rises=%0d at=%0d exp rises=%0d at=%0d", rise_cnt - r0, rise_cyc, 1, s + 80);
    end
    checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rx_data got data=%h vld=%b exp 3c 1", out_data, out_valid);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rx_hold got vld=%b exp=1", out_valid);
    end
    consume();
  endtask

  task automatic test_false_start_and_frame_err;
    int r0;
    int e0;
    int s;
    r0 = rise_cnt;
    e0 = err_cnt;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rise_cnt !== r0 || err_cnt !== e0) begin
      failures++;
      $display("FAIL false_start got rises=%0d errs=%0d exp 0 0", rise_cnt - r0, err_cnt - e0);
    end
    s = cyc;
    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (err_cnt !== e0 + 1 || err_cyc !== s + 79) begin
      failures++;
      $display("FAIL frame_err_pulse got count=%0d at=%0d exp 1 at %0d", err_cnt - e0, err_cyc, s + 79);
    end
    checks++;
    if (rise_cnt !== r0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_no_data got rises=%0d vld=%b exp 0 0", rise_cnt - r0, out_valid);
    end
  endtask

  task automatic test_break;
    int r0;
    int e0;
    r0 = rise_cnt;
    e0 = err_cnt;
    uart_rx = 1'b0;
    repeat (30 * N) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * N) @(negedge clk);
    send_rx(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (rise_cnt !== r0 + 1 || out_data !== 8'h12) begin
      failures++;
      $display("FAIL break_recover got rises=%0d data=%h exp 1 12", rise_cnt - r0, out_data);
    end
    checks++;
    if (err_cnt !== e0 + 1) begin
      failures++;
      $display("FAIL break_err got errs=%0d exp=1", err_cnt - e0);
    end
    consume();
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_cnt;
    out_ready = 1'b0;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (out_data !== 8'h11 || out_valid !== 1'b1 || ovr_cnt !== o0 + 1) begin
      failures++;
      $display("FAIL overrun got data=%h vld=%b ovr=%0d exp 11 1 1", out_data, out_valid, ovr_cnt - o0);
    end
    consume();
  endtask

  task automatic test_coincident_handshake;
    int o0;
    out_ready = 1'b0;
    send_rx(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 8'h11 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL coinc_first got data=%h vld=%b exp 11 1", out_data, out_valid);
    end
    o0 = ovr_cnt;
    fork
      send_rx(8'h22, 1'b1);
      begin
        repeat (79) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    checks++;
    if (out_data !== 8'h22 || out_valid !== 1'b1 || ovr_cnt !== o0) begin
      failures++;
      $display("FAIL coinc_load got data=%h vld=%b ovr=%0d exp 22 1 0", out_data, out_valid, ovr_cnt - o0);
    end
    consume();
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5 * N + 3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_pre got tx=%b rdy=%b exp 0 0", uart_tx, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got tx=%b rdy=%b exp 1 1", uart_tx, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_tx_and_check(8'h5A);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_false_start_and_frame_err();
    test_break();
    test_overrun();
    test_coincident_handshake();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
